bldc_gate_deadtime: RTL
=======================

Name: bldc_gate_deadtime

Overview:
- Downstream stage of the UART-fed sensored BLDC controller.
- Consumes the 24-bit commutation pattern PT: 4 motors x 3 phase legs x {high, low}.
- Produces the gate-drive outputs GD, with dead time inserted on every leg, shoot-through requests rejected, and a latched kill/fault shutdown.
- PT originates in a different clock domain, so it is synchronised into clk first.

Parameters:
- DEAD_CYCLES, 50, clk cycles both switches of a leg stay off between conductions (1 us at 50 MHz); legal range 1..255.
- CNT_W, 8, dead-time counter width; must satisfy DEAD_CYCLES <= 2^CNT_W - 1.
- SYNC_STAGES, 2, synchroniser depth for PT and kill.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- PT  input  24  requested pattern; leg n (n = 3*motor + phase, 0..11) uses PT[2n+1] = high-side request and PT[2n] = low-side request.
- en  input  1  synchronous enable; when 0, all legs go to OFF via dead time.
- kill  input  1  external fault, active-high; synchronised before use.
- clear_fault  input  1  one-cycle pulse; clears fault_latched only if synchronised kill = 0.
- GD  output  24  gate drives, same bit mapping as PT.
- fault_latched  output  1  sticky shutdown flag.
- illegal  output  4  sticky per-motor flag: some leg of that motor requested high and low together.

Behaviour:
- Reset (reset = 0, asynchronous): GD = 0, fault_latched = 0, illegal = 0, synchronisers cleared, every leg in IDLE with its counter = 0.
- PT and kill each pass through SYNC_STAGES flops; call the results ps and ks.
- Leg target, evaluated in priority order:
  - OFF if fault_latched, ks, or en = 0.
  - OFF if the leg's ps pair = 11.
  - HIGH if the pair = 10.
  - LOW if the pair = 01.
  - OFF if the pair = 00.
- Per-leg FSM, all outputs registered:
  - IDLE (GD pair 00): target HIGH -> ON_H; target LOW -> ON_L; otherwise stay.
  - ON_H (pair 10): target != HIGH -> DEAD, counter loaded with DEAD_CYCLES-1.
  - ON_L (pair 01): target != LOW -> DEAD, counter loaded with DEAD_CYCLES-1.
  - DEAD (pair 00): counter decrements each cycle. At 0, go to ON_H, ON_L or IDLE per the target sampled that cycle.
  - Target changes during DEAD never shorten it. A target that returns to the previous side still waits the full dead time.
- Invariant: a GD pair is never 11, and a leg never moves between ON_H and ON_L without DEAD_CYCLES cycles of 00 in between.
- Latency:
  - PT edge to GD change from IDLE: SYNC_STAGES + 1 cycles (3 by default).
  - Direct side swap: new side asserts SYNC_STAGES + 1 + DEAD_CYCLES cycles after the PT edge.
- Fault handling:
  - fault_latched sets on the cycle ks = 1 and stays set while ks = 1.
  - While fault_latched = 1, all ON legs enter DEAD on the next edge. GD goes to 0 one cycle after ks.
  - clear_fault while ks = 1 is ignored.
  - After a legal clear, legs resume from their current state (IDLE, or DEAD completing its count).
- illegal[m] sets when any leg of motor m has its synchronised pair = 11. It is cleared only by reset.
- en = 0 behaves like target OFF; it does not set fault_latched.
- Simultaneous events:
  - clear_fault and a rising ks in the same cycle: fault stays set.
  - Any illegal pair with en = 0: the flag is still recorded.
- Counter width: it only ever loads DEAD_CYCLES-1 and decrements to 0, so it never wraps.

Decomposition:
- Package bldc_gate_pkg holds:
  - leg state enum {IDLE, ON_H, ON_L, DEAD}, 2-bit encoding;
  - constants NUM_MOTORS = 4, LEGS_PER_MOTOR = 3, NUM_LEGS = 12;
  - the PT bit-index helper mapping leg n to bits 2n+1 and 2n.
- One natural sub-module: bldc_leg_deadtime, containing one leg's FSM and counter. It is instantiated 12 times in a generate loop.
- The top level holds the synchronisers, the fault latch and the illegal flags.

Test Plan:
- Reset released, en = 1, PT = 24'h000002 (leg 0 high) -> GD[1:0] = 10 on cycle 3; all other GD bits stay 0.
- Leg 0 driven 10, then PT[1:0] switched to 01 -> GD[1:0] = 00 for exactly 50 cycles, then 01; never 11.
- Leg 0 driven 10, PT[1:0] = 01 for 10 cycles, then back to 10 -> GD[1:0] = 00 for a full 50 cycles, then 10.
- PT[7:6] = 11 (motor 1, leg 3) -> GD[7:6] stays 00, illegal = 4'b0010 and stays set after PT returns to 00.
- All legs ON, kill pulsed high for 1 cycle -> GD = 0 within 1 cycle of ks; fault_latched = 1. clear_fault while kill = 1 is ignored; after kill = 0, clear_fault restores operation once the dead time expires.
- reset asserted mid-DEAD (counter = 20) -> GD = 0 immediately and asynchronously; after release the leg starts from IDLE with counter 0.

Source files
------------

// File: rtl/bldc_gate_pkg.sv
// Shared types and constants for the BLDC gate-drive dead-time stage.
// A leg is one half-bridge: PT/GD bit 2n+1 drives its high side and bit 2n its low side.
package bldc_gate_pkg;
  localparam int NUM_MOTORS     = 4;
  localparam int LEGS_PER_MOTOR = 3;
  localparam int NUM_LEGS       = NUM_MOTORS * LEGS_PER_MOTOR;

  typedef enum logic [1:0] {IDLE = 2'd0, ON_H = 2'd1, ON_L = 2'd2, DEAD = 2'd3} leg_state_e;
  typedef enum logic [1:0] {TGT_OFF = 2'd0, TGT_HIGH = 2'd1, TGT_LOW = 2'd2} leg_target_e;

  function automatic int hi_bit(input int n);
    return 2 * n + 1;
  endfunction

  function automatic int lo_bit(input int n);
    return 2 * n;
  endfunction
endpackage

// File: rtl/bldc_leg_deadtime.sv
// One half-bridge leg: FSM plus dead-time counter, registered gate outputs.
// gd = {high, low}; never 11, and a side swap always passes through DEAD_CYCLES of 00.
module bldc_leg_deadtime
  import bldc_gate_pkg::*;
#(
  parameter int DEAD_CYCLES = 50,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  leg_target_e target,
  output logic [1:0]  gd
);
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

  leg_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       gd_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      gd    <= 2'b00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      gd    <= gd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (target == TGT_HIGH)     state_nxt = ON_H;
        else if (target == TGT_LOW) state_nxt = ON_L;
      end
      ON_H: begin
        if (target != TGT_HIGH) begin
          state_nxt = DEAD;
          cnt_nxt   = DEAD_LOAD;
        end
      end
      ON_L: begin
        if (target != TGT_LOW) begin
          state_nxt = DEAD;
          cnt_nxt   = DEAD_LOAD;
        end
      end
      DEAD: begin
        // Dead time always runs to completion; only the target at expiry matters.
        if (cnt == '0) begin
          case (target)
            TGT_HIGH: state_nxt = ON_H;
            TGT_LOW:  state_nxt = ON_L;
            default:  state_nxt = IDLE;
          endcase
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    gd_nxt = (state_nxt == ON_H) ? 2'b10 :
             (state_nxt == ON_L) ? 2'b01 : 2'b00;
  end
endmodule

// File: rtl/bldc_gate_deadtime.sv
// Gate-drive stage: synchronises PT/kill, holds the fault latch and illegal-request
// flags, and resolves a per-leg target for twelve dead-time leg FSMs.
module bldc_gate_deadtime
  import bldc_gate_pkg::*;
#(
  parameter int DEAD_CYCLES = 50,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2*NUM_LEGS-1:0]   PT,
  input  logic                    en,
  input  logic                    kill,
  input  logic                    clear_fault,
  output logic [2*NUM_LEGS-1:0]   GD,
  output logic                    fault_latched,
  output logic [NUM_MOTORS-1:0]   illegal
);
  logic [SYNC_STAGES-1:0][2*NUM_LEGS-1:0] pt_sync;
  logic [SYNC_STAGES-1:0]                 kill_sync;
  logic [2*NUM_LEGS-1:0]                  ps;
  logic                                   ks;
  logic                                   leg_off;
  logic [NUM_LEGS-1:0]                    pair_bad;
  logic [NUM_LEGS-1:0][1:0]               gd_leg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pt_sync   <= '0;
      kill_sync <= '0;
    end else begin
      pt_sync[0]   <= PT;
      kill_sync[0] <= kill;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        pt_sync[i]   <= pt_sync[i-1];
        kill_sync[i] <= kill_sync[i-1];
      end
    end
  end

  assign ps      = pt_sync[SYNC_STAGES-1];
  assign ks      = kill_sync[SYNC_STAGES-1];
  assign leg_off = fault_latched | ks | ~en;

  // A live kill dominates clear_fault, including a clear that coincides with its rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_latched <= 1'b0;
      illegal       <= '0;
    end else begin
      fault_latched <= ks | (fault_latched & ~clear_fault);
      for (int m = 0; m < NUM_MOTORS; m++)
        illegal[m] <= illegal[m] | (|pair_bad[m*LEGS_PER_MOTOR +: LEGS_PER_MOTOR]);
    end
  end

  for (genvar n = 0; n < NUM_LEGS; n++) begin : g_leg
    logic [1:0]  pair;
    leg_target_e target;

    assign pair        = {ps[hi_bit(n)], ps[lo_bit(n)]};
    assign pair_bad[n] = (pair == 2'b11);

    always_comb begin
      target = TGT_OFF;
      if (!leg_off) begin
        if (pair == 2'b10)      target = TGT_HIGH;
        else if (pair == 2'b01) target = TGT_LOW;
      end
    end

    bldc_leg_deadtime #(
      .DEAD_CYCLES (DEAD_CYCLES),
      .CNT_W       (CNT_W)
    ) u_leg (
      .clk    (clk),
      .reset  (reset),
      .target (target),
      .gd     (gd_leg[n])
    );

    assign GD[hi_bit(n)] = gd_leg[n][1];
    assign GD[lo_bit(n)] = gd_leg[n][0];
  end
endmodule
